// File: rtl/wdt_multi.sv
// Multi-channel watchdog: NUM_CH independent channels sharing one prescaler, each with
// a timeout, an optional early-kick window and sticky fault flags.
module wdt_multi #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CNT_W  = 32,
    parameter int unsigned PRE_W  = 8,
    localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] en,
    input  logic [NUM_CH-1:0] kick,
    input  logic [NUM_CH-1:0] clr,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_timeout,
    input  logic [CNT_W-1:0]  cfg_window,
    input  logic              cfg_pre_we,
    input  logic [PRE_W-1:0]  cfg_prescale,
    output logic [NUM_CH-1:0] wto,
    output logic [NUM_CH-1:0] win_err,
    output logic              wto_any
);

    typedef enum logic [1:0] {StDisabled, StRun, StExpired} ch_state_e;

    logic [PRE_W-1:0]  pre_cnt_q, pre_cnt_d;
    logic [PRE_W-1:0]  prescale_q, prescale_d;
    logic              tick;

    ch_state_e         state_q   [NUM_CH];
    ch_state_e         state_d   [NUM_CH];
    logic [CNT_W-1:0]  count_q   [NUM_CH];
    logic [CNT_W-1:0]  count_d   [NUM_CH];
    logic [CNT_W-1:0]  timeout_q [NUM_CH];
    logic [CNT_W-1:0]  timeout_d [NUM_CH];
    logic [CNT_W-1:0]  window_q  [NUM_CH];
    logic [CNT_W-1:0]  window_d  [NUM_CH];
    logic [NUM_CH-1:0] wto_q, wto_d;
    logic [NUM_CH-1:0] win_err_q, win_err_d;
    logic              wto_any_q;

    assign tick = (pre_cnt_q == prescale_q);

    always_comb begin
        prescale_d = prescale_q;
        pre_cnt_d  = tick ? '0 : pre_cnt_q + PRE_W'(1);
        if (cfg_pre_we) begin
            prescale_d = cfg_prescale;
            pre_cnt_d  = '0;
        end
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        timeout_d = timeout_q;
        window_d  = window_q;
        wto_d     = wto_q;
        win_err_d = win_err_q;
        for (int i = 0; i < NUM_CH; i++) begin
            case (state_q[i])
                StDisabled: begin
                    count_d[i] = '0;
                    if (en[i]) state_d[i] = StRun;
                    // Config is only accepted while the channel is idle; indices past NUM_CH
                    // never match any channel.
                    if (cfg_we && (cfg_ch == CH_W'(i))) begin
                        timeout_d[i] = cfg_timeout;
                        window_d[i]  = cfg_window;
                    end
                end
                StRun: begin
                    if (!en[i]) begin
                        state_d[i] = StDisabled;
                        count_d[i] = '0;
                    end else if (kick[i]) begin
                        if ((window_q[i] == '0) || (count_q[i] >= window_q[i])) begin
                            count_d[i] = '0;
                        end else begin
                            win_err_d[i] = 1'b1;
                            wto_d[i]     = 1'b1;
                            state_d[i]   = StExpired;
                        end
                    end else if (tick) begin
                        if (count_q[i] >= timeout_q[i]) begin
                            wto_d[i]   = 1'b1;
                            state_d[i] = StExpired;
                        end else begin
                            count_d[i] = count_q[i] + CNT_W'(1);
                        end
                    end
                end
                StExpired: begin
                    if (clr[i]) begin
                        wto_d[i]     = 1'b0;
                        win_err_d[i] = 1'b0;
                        count_d[i]   = '0;
                        state_d[i]   = en[i] ? StRun : StDisabled;
                    end
                end
                default: begin
                    state_d[i] = StDisabled;
                    count_d[i] = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pre_cnt_q  <= '0;
            prescale_q <= '0;
            wto_q      <= '0;
            win_err_q  <= '0;
            wto_any_q  <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i]   <= StDisabled;
                count_q[i]   <= '0;
                timeout_q[i] <= '1;
                window_q[i]  <= '0;
            end
        end else begin
            pre_cnt_q  <= pre_cnt_d;
            prescale_q <= prescale_d;
            state_q    <= state_d;
            count_q    <= count_d;
            timeout_q  <= timeout_d;
            window_q   <= window_d;
            wto_q      <= wto_d;
            win_err_q  <= win_err_d;
            wto_any_q  <= |wto_q;
        end
    end

    assign wto     = wto_q;
    assign win_err = win_err_q;
    assign wto_any = wto_any_q;

endmodule

// File: tb/tb_wdt_multi.sv
// Bench for wdt_multi: directed timing checks plus a randomized run scored against a
// cycle-level reference model through an expected-output queue.
module tb_wdt_multi;

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned CNT_W  = 32;
    localparam int unsigned PRE_W  = 8;
    localparam int unsigned CH_W   = 2;
    localparam longint unsigned CNT_MAX = (64'd1 << CNT_W) - 1;
    localparam int MDIS = 0;
    localparam int MRUN = 1;
    localparam int MEXP = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NUM_CH-1:0] en, kick, clr;
    logic              cfg_we, cfg_pre_we;
    logic [CH_W-1:0]   cfg_ch;
    logic [CNT_W-1:0]  cfg_timeout, cfg_window;
    logic [PRE_W-1:0]  cfg_prescale;
    logic [NUM_CH-1:0] wto, win_err;
    logic              wto_any;

    wdt_multi #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .PRE_W(PRE_W)) dut (
        .clk(clk), .rst(rst), .en(en), .kick(kick), .clr(clr),
        .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_timeout(cfg_timeout), .cfg_window(cfg_window),
        .cfg_pre_we(cfg_pre_we), .cfg_prescale(cfg_prescale),
        .wto(wto), .win_err(win_err), .wto_any(wto_any)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    logic [31:0] exp_q [$];

    // Reference model state
    int              m_mode [NUM_CH];
    longint unsigned m_cnt  [NUM_CH];
    longint unsigned m_to   [NUM_CH];
    longint unsigned m_win  [NUM_CH];
    bit [NUM_CH-1:0] m_wto, m_werr;
    bit              m_any;
    int              m_pre, m_ps;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        else n_pass++;
    endtask

    function automatic void model_edge();
        bit tick, any_next, was_dis;
        any_next = |m_wto;
        if (!rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                m_mode[c] = MDIS; m_cnt[c] = 0; m_to[c] = CNT_MAX; m_win[c] = 0;
            end
            m_wto = '0; m_werr = '0; m_any = 0; m_pre = 0; m_ps = 0;
            return;
        end
        tick = (m_pre == m_ps);
        for (int c = 0; c < NUM_CH; c++) begin
            was_dis = (m_mode[c] == MDIS);
            if (m_mode[c] == MDIS) begin
                if (en[c]) m_mode[c] = MRUN;
            end else if (m_mode[c] == MRUN) begin
                if (!en[c]) begin
                    m_mode[c] = MDIS; m_cnt[c] = 0;
                end else if (kick[c] && m_win[c] != 0 && m_cnt[c] < m_win[c]) begin
                    m_werr[c] = 1; m_wto[c] = 1; m_mode[c] = MEXP;
                end else if (kick[c]) begin
                    m_cnt[c] = 0;
                end else if (tick && m_cnt[c] >= m_to[c]) begin
                    m_wto[c] = 1; m_mode[c] = MEXP;
                end else if (tick) begin
                    m_cnt[c]++;
                end
            end else if (clr[c]) begin
                m_wto[c] = 0; m_werr[c] = 0; m_cnt[c] = 0;
                m_mode[c] = en[c] ? MRUN : MDIS;
            end
            if (was_dis && cfg_we && int'(cfg_ch) == c) begin
                m_to[c] = cfg_timeout; m_win[c] = cfg_window;
            end
        end
        m_any = any_next;
        if (cfg_pre_we) begin
            m_ps = int'(cfg_prescale); m_pre = 0;
        end else if (tick) m_pre = 0;
        else m_pre++;
    endfunction

    // One clock: model predicts, expectation queued, pulses drop after the edge.
    task automatic step();
        model_edge();
        exp_q.push_back({23'd0, m_any, m_werr, m_wto});
        @(posedge clk);
        #1;
        kick = '0; clr = '0; cfg_we = 0; cfg_pre_we = 0;
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic cfg(input int ch, input int t, input int w);
        cfg_we = 1; cfg_ch = CH_W'(ch); cfg_timeout = CNT_W'(t); cfg_window = CNT_W'(w);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [31:0] e;
            e = exp_q.pop_front();
            check("sb_outputs", {23'd0, wto_any, win_err, wto}, e);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL sim_timeout: got no finish expected finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        rst = 0; en = '1; kick = '0; clr = '0; cfg_we = 0; cfg_pre_we = 0;
        cfg_ch = '0; cfg_timeout = '0; cfg_window = '0; cfg_prescale = '0;

        // Reset with all channels enabled
        run(2);
        check("rst_wto", 32'(wto), 0);
        check("rst_win_err", 32'(win_err), 0);
        check("rst_wto_any", 32'(wto_any), 0);
        rst = 1;
        run(5);
        check("rst_run_no_expire", 32'(wto), 0);
        en = '0;
        step();

        // Basic timeout on ch0
        cfg_pre_we = 1; cfg_prescale = 0; step();
        cfg(0, 10, 0); step();
        en[0] = 1; step();
        run(10);
        check("basic_wto_before", 32'(wto[0]), 0);
        step();
        check("basic_wto_at_11", 32'(wto[0]), 1);
        check("basic_any_lags", 32'(wto_any), 0);
        step();
        check("basic_any_next", 32'(wto_any), 1);
        check("basic_others", 32'(wto[3:1]), 0);
        en[0] = 0; clr[0] = 1; step();
        check("clr_wto_low", 32'(wto[0]), 0);
        step();
        check("clr_any_low", 32'(wto_any), 0);

        // Refresh on ch1
        cfg(1, 10, 0); step();
        en[1] = 1; step();
        for (int i = 0; i < 200; i++) begin
            if (i % 8 == 7) kick[1] = 1;
            step();
        end
        check("refresh_held", 32'(wto[1]), 0);
        kick[1] = 1; step();
        run(10);
        check("refresh_before", 32'(wto[1]), 0);
        step();
        check("refresh_expire_11", 32'(wto[1]), 1);
        en[1] = 0; clr[1] = 1; step();

        // Window on ch2
        cfg(2, 20, 5); step();
        en[2] = 1; step();
        run(3);
        kick[2] = 1; step();
        check("win_early_err", 32'(win_err[2]), 1);
        check("win_early_wto", 32'(wto[2]), 1);
        clr[2] = 1; step();
        check("win_clr_err", 32'(win_err[2]), 0);
        check("win_clr_wto", 32'(wto[2]), 0);
        run(5);
        kick[2] = 1; step();
        check("win_legal_err", 32'(win_err[2]), 0);
        check("win_legal_wto", 32'(wto[2]), 0);
        en[2] = 0; step();

        // Prescaler and config lock on ch3
        cfg(3, 4, 0); step();
        cfg_pre_we = 1; cfg_prescale = 3; en[3] = 1; step();
        for (int k = 1; k <= 20; k++) begin
            if (k == 2) cfg(3, 100, 0);
            step();
            if (k == 19) check("pre_before_20", 32'(wto[3]), 0);
            if (k == 20) check("pre_expire_20", 32'(wto[3]), 1);
        end
        en[3] = 0; clr[3] = 1; step();
        cfg_pre_we = 1; cfg_prescale = 0; step();

        // Kick coinciding with a tick at count == timeout
        en[0] = 1; step();
        run(10);
        kick[0] = 1; step();
        check("kick_at_timeout", 32'(wto[0]), 0);
        run(10);
        check("kick_reset_before", 32'(wto[0]), 0);
        step();
        check("kick_reset_expire", 32'(wto[0]), 1);
        rst = 0; step();
        check("rst_expired_wto", 32'(wto[0]), 0);
        check("rst_expired_any", 32'(wto_any), 0);
        rst = 1; en = '0; step();

        // clr and kick together while expired
        cfg(0, 2, 0); step();
        en[0] = 1; step();
        run(3);
        check("ck_expired", 32'(wto[0]), 1);
        kick[0] = 1; clr[0] = 1; step();
        check("ck_clr_wins", 32'(wto[0]), 0);
        run(2);
        check("ck_restart_before", 32'(wto[0]), 0);
        step();
        check("ck_restart_expire", 32'(wto[0]), 1);
        en[0] = 0; clr[0] = 1; step();

        // Randomized traffic, scored by the model only
        for (int i = 0; i < 3000; i++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if ($urandom_range(0, 15) == 0) en[c] = ~en[c];
                kick[c] = ($urandom_range(0, 5) == 0);
                clr[c]  = ($urandom_range(0, 7) == 0);
            end
            if ($urandom_range(0, 7) == 0)
                cfg(int'($urandom_range(0, NUM_CH - 1)), int'($urandom_range(0, 30)),
                    ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(0, 20)));
            if ($urandom_range(0, 49) == 0) begin
                cfg_pre_we = 1; cfg_prescale = PRE_W'($urandom_range(0, 3));
            end
            rst = ($urandom_range(0, 299) != 0);
            step();
        end
        rst = 1;

        for (int k = 0; k < 4 && exp_q.size() > 0; k++) @(negedge clk);
        #1;
        if (exp_q.size() != 0) check("sb_drain", 32'(exp_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
